// File: rtl/sub_bytes_engine.sv
// Sequential AES SubBytes / InvSubBytes engine: one 128-bit state per transaction,
// LANES bytes substituted per clock, forward or inverse mode latched at acceptance.

module gf_inverse (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] m);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) p = p ^ t;
            t = t[7] ? ({t[6:0], 1'b0} ^ 8'h1b) : {t[6:0], 1'b0};
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); zero maps to zero as AES requires
    logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;

    always_comb begin
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a6   = gf_mul(a3, a3);
        a12  = gf_mul(a6, a6);
        a15  = gf_mul(a12, a3);
        a30  = gf_mul(a15, a15);
        a60  = gf_mul(a30, a30);
        a120 = gf_mul(a60, a60);
        a240 = gf_mul(a120, a120);
        a252 = gf_mul(a240, a12);
        y    = gf_mul(a252, a2);
    end
endmodule

module sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] x;

    gf_inverse u_inv (.a(a), .y(x));

    assign y = x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
endmodule

module inverse_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] t;

    assign t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;

    gf_inverse u_inv (.a(t), .y(y));
endmodule

// state | meaning
// IDLE  | waiting for a state, in_ready=1
// RUN   | substituting chunk ptr of the work register each cycle
// DONE  | result presented on out_data until out_ready; may accept the next state
module sub_bytes_engine #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam int CHUNKS = 16 / LANES;
    localparam int PTR_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(CHUNKS - 1);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [0:15][7:0]     work, work_sub;
    logic                 mode;
    logic [PTR_W-1:0]     ptr;
    logic                 load, advance;
    logic [3:0]           lane_idx [LANES];
    logic [7:0]           lane_in  [LANES];
    logic [7:0]           fwd_out  [LANES];
    logic [7:0]           inv_out  [LANES];

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l] = 4'(int'(ptr) * LANES + l);
            lane_in[l]  = work[lane_idx[l]];
        end
    end

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            sbox         u_fwd (.a(lane_in[g]), .y(fwd_out[g]));
            inverse_sbox u_inv (.a(lane_in[g]), .y(inv_out[g]));
        end
    endgenerate

    always_comb begin
        work_sub = work;
        for (int l = 0; l < LANES; l++) begin
            work_sub[lane_idx[l]] = mode ? inv_out[l] : fwd_out[l];
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        advance    = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                advance = 1'b1;
                if (ptr == LAST) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load       = 1'b1;
                        state_next = RUN;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            work  <= '0;
            mode  <= 1'b0;
            ptr   <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                work <= in_data;
                mode <= in_inv;
                ptr  <= '0;
            end else if (advance) begin
                work <= work_sub;
                if (ptr != LAST) ptr <= ptr + 1'b1;
            end
        end
    end

    assign out_data = work;
endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed + randomized bench for sub_bytes_engine; S-box reference tables are built
// by brute-force field inversion and the bitwise affine definition.

module tb_sub_bytes_engine;
    localparam int LANES  = 4;
    localparam int CHUNKS = 16 / LANES;
    localparam int LAT    = CHUNKS + 1;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] fwd_tbl [256];
    logic [7:0] inv_tbl [256];

    sub_bytes_engine #(.LANES(LANES)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_inv   (in_inv),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = t[7] ? ((t << 1) ^ 8'h1b) : (t << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
        logic [127:0] r;
        logic [127:0] s;
        r = '0;
        s = d;
        for (int k = 0; k < 16; k++) begin
            r = {r[119:0], inv ? inv_tbl[s[127:120]] : fwd_tbl[s[127:120]]};
            s = s << 8;
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkint(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Starts and ends at a negedge with the engine idle.
    task automatic run_txn(input string tag, input logic [127:0] d, input logic inv,
                           input bit toggle, input logic [127:0] exp);
        int lat;
        in_data   = d;
        in_inv    = inv;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #1 chk1({tag, "_in_ready_idle"}, in_ready, 1'b1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = rnd128();
        if (LANES < 16) chk1({tag, "_busy"}, busy, 1'b1);
        while (!out_valid && lat < 64) begin
            if (toggle) in_inv = ~in_inv;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chkint({tag, "_latency"}, lat, LAT);
        chk128({tag, "_data"}, out_data, exp);
        out_ready = 1'b1;
        #1 chk1({tag, "_in_ready_done"}, in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk1({tag, "_out_valid_after"}, out_valid, 1'b0);
    endtask

    initial begin
        logic [7:0]   xi, bb, cc;
        logic [127:0] d, exp;
        logic [127:0] d_list [8];
        logic         v_list [8];
        logic [127:0] expq [$];
        int           idx, got, cyc, last_out, wait_cnt;
        bit           acc;

        cc = 8'h63;
        for (int x = 0; x < 256; x++) begin
            xi = 8'h00;
            for (int y = 1; y < 256; y++)
                if (ref_mul(8'(x), 8'(y)) == 8'h01) xi = 8'(y);
            for (int i = 0; i < 8; i++)
                bb[3'(i)] = xi[3'(i)] ^ xi[3'(i + 4)] ^ xi[3'(i + 5)] ^ xi[3'(i + 6)]
                          ^ xi[3'(i + 7)] ^ cc[3'(i)];
            fwd_tbl[8'(x)] = bb;
            inv_tbl[bb]    = 8'(x);
        end

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_inv = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("reset_in_ready", in_ready, 1'b1);
        chk1("reset_out_valid", out_valid, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        chk128("reset_out_data", out_data, 128'h0);
        @(negedge clk);

        run_txn("fwd_vec", 128'h00112233445566778899aabbccddeeff, 1'b0, 1'b0,
                128'h638293c31bfc33f5c4eeacea4bc12816);
        run_txn("inv_vec", 128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1, 1'b0,
                128'h00112233445566778899aabbccddeeff);

        for (int t = 0; t < 8; t++) begin
            d = rnd128();
            run_txn($sformatf("rand%0d", t), d, 1'(t), 1'b0, model(d, 1'(t)));
        end

        // backpressure in DONE
        d = rnd128();
        exp = model(d, 1'b1);
        in_valid = 1'b1; in_data = d; in_inv = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_cnt = 0;
        while (!out_valid && wait_cnt < 64) begin
            @(posedge clk); @(negedge clk); wait_cnt++;
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'(i);
            in_data  = rnd128();
            in_inv   = 1'($urandom);
            #1;
            chk1($sformatf("bp_out_valid%0d", i), out_valid, 1'b1);
            chk1($sformatf("bp_in_ready%0d", i), in_ready, 1'b0);
            chk128($sformatf("bp_data%0d", i), out_data, exp);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1 chk1("bp_release_in_ready", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk1("bp_idle_out_valid", out_valid, 1'b0);
        chk1("bp_idle_busy", busy, 1'b0);
        chk1("bp_idle_in_ready", in_ready, 1'b1);
        repeat (3) @(negedge clk);
        chk1("bp_no_duplicate", out_valid, 1'b0);

        // back-to-back streaming
        d_list[0] = '0;             v_list[0] = 1'b0;
        d_list[1] = {16{8'h63}};    v_list[1] = 1'b1;
        for (int i = 2; i < 8; i++) begin
            d_list[i] = rnd128();
            v_list[i] = 1'(i);
        end
        idx = 0; got = 0; cyc = 0; last_out = -1;
        in_valid = 1'b1; in_data = d_list[0]; in_inv = v_list[0]; out_ready = 1'b1;
        while (got < 8 && cyc < 500) begin
            #1;
            acc = in_valid && in_ready;
            if (out_valid) begin
                if (expq.size() > 0) begin
                    exp = expq.pop_front();
                    chk128($sformatf("b2b_data%0d", got), out_data, exp);
                end else begin
                    chkint("b2b_unexpected_output", 1, 0);
                end
                if (last_out >= 0) chkint($sformatf("b2b_spacing%0d", got), cyc - last_out, LAT);
                last_out = cyc;
                got++;
            end
            if (acc) expq.push_back(model(in_data, in_inv));
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (acc) begin
                idx++;
                if (idx < 8) begin
                    in_data = d_list[idx];
                    in_inv  = v_list[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chkint("b2b_count", got, 8);
        chkint("b2b_accepted", idx, 8);
        chk128("b2b_first_fwd", d_list[0] ^ 128'h0, 128'h0);
        @(negedge clk);

        // reset mid-RUN at ptr=1
        in_valid = 1'b1; in_data = rnd128(); in_inv = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("rst_run_out_valid", out_valid, 1'b0);
        chk1("rst_run_in_ready", in_ready, 1'b1);
        chk1("rst_run_busy", busy, 1'b0);
        chk128("rst_run_out_data", out_data, 128'h0);
        @(negedge clk);
        d = rnd128();
        run_txn("after_rst", d, 1'b1, 1'b0, model(d, 1'b1));

        // mode is latched at acceptance
        run_txn("mode_latch", {16{8'h53}}, 1'b0, 1'b1, {16{8'hed}});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
